// File: rtl/fpu_mmio_ctrl_if.sv
// ----------------------------------------------------------------------------
// fpu_mmio_ctrl_if
// Bundles the Memory-stage register-window bus and the FPU launch/complete
// handshake used by fpu_mmio_ctrl.
//   slave  : view taken by fpu_mmio_ctrl (bus inputs in, FPU controls out)
//   master : view taken by the surrounding core / FPU model
// Signals:
//   mem_addr/mem_we/mem_re/mem_wdata : Memory-stage access
//   sel/mem_rdata/mem_stall          : window hit, read data, stall request
//   fpu_start/fpu_op/fpu_a/fpu_b     : launch pulse, op select, operands
//   fpu_result/fpu_flags/fpu_done    : completion data and pulse
// ----------------------------------------------------------------------------
interface fpu_mmio_ctrl_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 4;

    logic [DATA_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic              sel;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;

    logic              fpu_start;
    logic [OP_W-1:0]   fpu_op;
    logic [DATA_W-1:0] fpu_a;
    logic [DATA_W-1:0] fpu_b;
    logic [DATA_W-1:0] fpu_result;
    logic [FLAG_W-1:0] fpu_flags;
    logic              fpu_done;

    modport slave (
        input  mem_addr, mem_we, mem_re, mem_wdata,
        input  fpu_result, fpu_flags, fpu_done,
        output sel, mem_rdata, mem_stall,
        output fpu_start, fpu_op, fpu_a, fpu_b
    );

    modport master (
        output mem_addr, mem_we, mem_re, mem_wdata,
        output fpu_result, fpu_flags, fpu_done,
        input  sel, mem_rdata, mem_stall,
        input  fpu_start, fpu_op, fpu_a, fpu_b
    );
endinterface

// File: rtl/fpu_mmio_ctrl.sv
// ----------------------------------------------------------------------------
// fpu_mmio_ctrl
// Memory-mapped sequencer between the Memory stage and a multi-cycle FPU.
// Holds OPA/OPB/CMD/STATUS/RESULT in a 32-byte window at BASE_ADDR, launches
// one FPU operation per CMD write and captures result/flags on completion or
// gives up after TIMEOUT_CYCLES wait cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : fpu_mmio_ctrl_if.slave (memory window + FPU handshake)
// Build option:
//   FPU_CTRL_STALL_EN : when defined, a RESULT read while busy stalls the
//                       pipeline until the operation finishes; otherwise
//                       mem_stall is tied 0.
// ----------------------------------------------------------------------------
module fpu_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    fpu_mmio_ctrl_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OFF_W-1:0] OFF_OPA    = 3'd0;
    localparam logic [OFF_W-1:0] OFF_OPB    = 3'd1;
    localparam logic [OFF_W-1:0] OFF_CMD    = 3'd2;
    localparam logic [OFF_W-1:0] OFF_STATUS = 3'd3;
    localparam logic [OFF_W-1:0] OFF_RESULT = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic [DATA_W-1:0]   opa_q,       opa_d;
    logic [DATA_W-1:0]   opb_q,       opb_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic [FLAG_W-1:0]   flags_q,     flags_d;
    logic                done_q,      done_d;
    logic                timeout_q,   timeout_d;
    logic                overrun_q,   overrun_d;
    logic [DATA_W-1:0]   fpu_a_q,     fpu_a_d;
    logic [DATA_W-1:0]   fpu_b_q,     fpu_b_d;
    logic [OP_W-1:0]     fpu_op_q,    fpu_op_d;
    logic                fpu_start_q, fpu_start_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic [OFF_W-1:0]    off_c;
    logic                sel_c;
    logic                wr_c;
    logic                cmd_wr_c;
    logic                rd_result_c;
    logic                busy_c;
    logic                stall_c;
    logic [DATA_W-1:0]   rdata_c;
    logic                unused_addr_bits;

    // Address decode
    assign off_c       = bus.mem_addr[4:2];
    assign sel_c       = (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign wr_c        = sel_c & bus.mem_we;
    assign cmd_wr_c    = wr_c & (off_c == OFF_CMD);
    assign rd_result_c = sel_c & bus.mem_re & (off_c == OFF_RESULT);
    assign busy_c      = (state_q != S_IDLE);
    assign unused_addr_bits = ^bus.mem_addr[1:0];

    // Early RESULT read holds the pipeline until the FSM returns to IDLE
`ifdef FPU_CTRL_STALL_EN
    assign stall_c = rd_result_c & busy_c;
`else
    assign stall_c = 1'b0;
`endif

    // Read mux, combinational from registers
    always_comb begin
        rdata_c = '0;
        if (sel_c) begin
            case (off_c)
                OFF_OPA:    rdata_c = opa_q;
                OFF_OPB:    rdata_c = opb_q;
                OFF_STATUS: rdata_c = {24'd0, flags_q, overrun_q, timeout_q, done_q, busy_c};
                OFF_RESULT: rdata_c = result_q;
                default:    rdata_c = '0;
            endcase
        end
    end

    // Next-state and register update
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        flags_d     = flags_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        fpu_start_d = 1'b0;
        cnt_d       = cnt_q;

        if (wr_c && (off_c == OFF_OPA)) opa_d = bus.mem_wdata;
        if (wr_c && (off_c == OFF_OPB)) opb_d = bus.mem_wdata;

        // Only a read that is actually accepted consumes the done flag
        if (rd_result_c && !stall_c) done_d = 1'b0;

        // CMD while an operation is in flight (including its last cycle) is dropped
        if (cmd_wr_c && busy_c) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_wr_c) begin
                    state_d     = S_ISSUE;
                    fpu_a_d     = opa_q;
                    fpu_b_d     = opb_q;
                    fpu_op_d    = bus.mem_wdata[OP_W-1:0];
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    overrun_d   = 1'b0;
                    fpu_start_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // Completion takes priority over the timeout limit
                if (bus.fpu_done) begin
                    result_d = bus.fpu_result;
                    flags_d  = bus.fpu_flags;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            fpu_start_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            fpu_start_q <= fpu_start_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.sel       = sel_c;
    assign bus.mem_rdata = rdata_c;
    assign bus.mem_stall = stall_c;
    assign bus.fpu_start = fpu_start_q;
    assign bus.fpu_op    = fpu_op_q;
    assign bus.fpu_a     = fpu_a_q;
    assign bus.fpu_b     = fpu_b_q;
endmodule

// File: tb/tb_fpu_mmio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fpu_mmio_ctrl
// Self-checking bench for fpu_mmio_ctrl. A behavioural FPU responds to
// fpu_start with a programmable latency; expected launch commands and read
// data are queued when stimulus is driven and compared when the DUT responds.
// ----------------------------------------------------------------------------
module tb_fpu_mmio_ctrl;
    localparam int unsigned TO   = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    localparam logic [2:0] O_OPA    = 3'd0;
    localparam logic [2:0] O_OPB    = 3'd1;
    localparam logic [2:0] O_CMD    = 3'd2;
    localparam logic [2:0] O_STATUS = 3'd3;
    localparam logic [2:0] O_RESULT = 3'd4;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpu_mmio_ctrl_if bus();

    fpu_mmio_ctrl #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    cmd_t        cmd_q[$];
    logic [31:0] rd_q[$];

    // FPU model controls (written by the main sequence only)
    bit          fpu_respond = 1'b0;
    int          fpu_lat     = 1;
    logic [31:0] fpu_res     = '0;
    logic [3:0]  fpu_flg     = '0;
    int          spur_req    = 0;
    int          spur_seen   = 0;
    int          start_cnt   = 0;

    logic [31:0] m_opa = '0;
    logic [31:0] m_opb = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [2:0] off);
        return BASE | {27'd0, off, 2'b00};
    endfunction

    // Count launch pulses independently of the responder
    always @(negedge clk) if (bus.fpu_start === 1'b1) start_cnt++;

    // Behavioural FPU: checks each launch against the queued command and responds
    initial begin
        cmd_t c;
        bus.fpu_done   = 1'b0;
        bus.fpu_result = '0;
        bus.fpu_flags  = '0;
        forever begin
            @(posedge clk); #1;
            if (spur_req != spur_seen) begin
                spur_seen      = spur_req;
                bus.fpu_done   = 1'b1;
                bus.fpu_result = 32'hDEAD_BEEF;
                bus.fpu_flags  = 4'hF;
                @(posedge clk); #1;
                bus.fpu_done   = 1'b0;
            end else if (bus.fpu_start === 1'b1) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_start", 32'(bus.fpu_start), 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    check("fpu_op", 32'(bus.fpu_op), 32'(c.op));
                    check("fpu_a", bus.fpu_a, c.a);
                    check("fpu_b", bus.fpu_b, c.b);
                end
                if (fpu_respond) begin
                    repeat (fpu_lat) @(posedge clk);
                    #1;
                    bus.fpu_done   = 1'b1;
                    bus.fpu_result = fpu_res;
                    bus.fpu_flags  = fpu_flg;
                    @(posedge clk); #1;
                    bus.fpu_done   = 1'b0;
                end
            end
        end
    end

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        bus.mem_addr  = addr_of(off);
        bus.mem_we    = 1'b1;
        bus.mem_wdata = d;
        @(posedge clk); #1;
        bus.mem_we    = 1'b0;
        if (off == O_OPA) m_opa = d;
        if (off == O_OPB) m_opb = d;
    endtask

    task automatic cmd(input logic [1:0] op, input bit expect_start);
        if (expect_start) cmd_q.push_back('{op: op, a: m_opa, b: m_opb});
        wr(O_CMD, {30'd0, op});
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus.mem_addr = addr_of(off);
        bus.mem_re   = 1'b1;
        rd_q.push_back(exp);
        #1;
        check(tag, bus.mem_rdata, rd_q.pop_front());
        @(posedge clk); #1;
        bus.mem_re   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        bus.mem_addr = addr_of(O_STATUS);
        #1;
        while (bus.mem_rdata[0] === 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) check({tag, "_wait_expired"}, 32'(n), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        reset         = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and address decode
        bus.mem_addr = addr_of(O_STATUS); #1;
        check("rst_status", bus.mem_rdata, 32'h0);
        check("rst_sel", 32'(bus.sel), 32'd1);
        check("rst_start", 32'(bus.fpu_start), 32'd0);
        check("rst_fpu_a", bus.fpu_a, 32'h0);
        check("rst_fpu_op", 32'(bus.fpu_op), 32'd0);
        check("rst_stall", 32'(bus.mem_stall), 32'd0);
        rd(O_RESULT, 32'h0, "rst_result");
        wr(O_OPA, 32'h1234_5678);
        bus.mem_addr = BASE + 32'h20; #1;
        check("out_of_window_sel", 32'(bus.sel), 32'd0);
        check("out_of_window_rdata", bus.mem_rdata, 32'h0);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'h0, "off5_read");
        rd(O_OPA, 32'h1234_5678, "opa_readback");

        // Add with 1-cycle FPU
        s0 = start_cnt;
        wr(O_OPA, 32'h3F80_0000);
        wr(O_OPB, 32'h4000_0000);
        fpu_respond = 1'b1; fpu_lat = 1; fpu_res = 32'h4040_0000; fpu_flg = 4'h0;
        cmd(2'b00, 1'b1);
        wait_idle("add");
        rd(O_STATUS, 32'h2, "add_status");
        rd(O_CMD, 32'h0, "cmd_read");
        rd(O_RESULT, 32'h4040_0000, "add_result");
        rd(O_STATUS, 32'h0, "add_status_cleared");
        check("add_start_count", 32'(start_cnt - s0), 32'd1);

        // Multiply with flags
        fpu_lat = 3; fpu_res = 32'h40C0_0000; fpu_flg = 4'b1010;
        cmd(2'b10, 1'b1);
        wait_idle("mul");
        rd(O_STATUS, 32'hA2, "mul_status");
        rd(O_RESULT, 32'h40C0_0000, "mul_result");

        // Completion on the timeout-limit cycle wins
        fpu_lat = TO; fpu_res = 32'h4110_0000; fpu_flg = 4'h0;
        cmd(2'b01, 1'b1);
        wait_idle("race");
        rd(O_STATUS, 32'h2, "race_status");

        // Timeout: busy for ISSUE + TO wait cycles, RESULT untouched
        fpu_respond = 1'b0;
        cmd(2'b11, 1'b1);
        bus.mem_addr = addr_of(O_STATUS); #1;
        n = 0;
        while (bus.mem_rdata[0] === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("timeout_busy_cycles", 32'(n), 32'(TO + 1));
        rd(O_STATUS, 32'h4, "timeout_status");
        rd(O_RESULT, 32'h4110_0000, "timeout_result_kept");

        // Overrun: second CMD and operand write while busy
        s0 = start_cnt;
        wr(O_OPA, 32'h1111_1111);
        wr(O_OPB, 32'h2222_2222);
        fpu_respond = 1'b1; fpu_lat = 5; fpu_res = 32'h3333_3333; fpu_flg = 4'h0;
        cmd(2'b10, 1'b1);
        wr(O_OPA, 32'h4444_4444);
        cmd(2'b11, 1'b0);
        check("ovr_fpu_a_held", bus.fpu_a, 32'h1111_1111);
        check("ovr_fpu_op_held", 32'(bus.fpu_op), 32'd2);
        wait_idle("overrun");
        check("ovr_fpu_op_after", 32'(bus.fpu_op), 32'd2);
        rd(O_STATUS, 32'hA, "ovr_status");
        rd(O_OPA, 32'h4444_4444, "ovr_opa_updated");
        check("ovr_start_count", 32'(start_cnt - s0), 32'd1);
        rd(O_RESULT, 32'h3333_3333, "ovr_result");

        // Early RESULT read one cycle after CMD
        fpu_lat = 6; fpu_res = 32'h4080_0000; fpu_flg = 4'h0;
        cmd(2'b01, 1'b1);
        bus.mem_addr = addr_of(O_RESULT);
        bus.mem_re   = 1'b1;
        #1;
        n = 0;
        while (bus.mem_stall === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
`ifdef FPU_CTRL_STALL_EN
        check("stall_cycles", 32'(n), 32'd7);
        rd_q.push_back(32'h4080_0000);
`else
        check("stall_cycles", 32'(n), 32'd0);
        rd_q.push_back(32'h3333_3333);
`endif
        check("stall_rdata", bus.mem_rdata, rd_q.pop_front());
        check("stall_low", 32'(bus.mem_stall), 32'd0);
        @(posedge clk); #1;
        bus.mem_re = 1'b0;
`ifdef FPU_CTRL_STALL_EN
        rd(O_STATUS, 32'h0, "stall_status_after");
`else
        wait_idle("stall");
        rd(O_STATUS, 32'h2, "stall_status_after");
        rd(O_RESULT, 32'h4080_0000, "stall_result_after");
`endif

        // Spurious done in IDLE is ignored
        spur_req++;
        repeat (4) @(posedge clk);
        rd(O_STATUS, 32'h0, "spur_status");
        rd(O_RESULT, 32'h4080_0000, "spur_result");

        // Asynchronous reset during WAIT
        fpu_respond = 1'b0;
        wr(O_OPA, 32'hAAAA_0001);
        wr(O_OPB, 32'hBBBB_0002);
        cmd(2'b11, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        bus.mem_addr = addr_of(O_STATUS);
        #1;
        check("arst_status", bus.mem_rdata, 32'h0);
        check("arst_fpu_a", bus.fpu_a, 32'h0);
        check("arst_fpu_b", bus.fpu_b, 32'h0);
        check("arst_fpu_op", 32'(bus.fpu_op), 32'd0);
        check("arst_start", 32'(bus.fpu_start), 32'd0);
        bus.mem_addr = addr_of(O_RESULT); #1;
        check("arst_result", bus.mem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_opa = '0;
        m_opb = '0;
        s0 = start_cnt;
        repeat (4) @(posedge clk);
        check("arst_no_start", 32'(start_cnt - s0), 32'd0);

        // Normal operation after reset
        wr(O_OPA, 32'h3F80_0000);
        wr(O_OPB, 32'h3F80_0000);
        fpu_respond = 1'b1; fpu_lat = 2; fpu_res = 32'h4000_0000; fpu_flg = 4'b0001;
        cmd(2'b00, 1'b1);
        wait_idle("post_reset");
        rd(O_STATUS, 32'h12, "post_reset_status");
        rd(O_RESULT, 32'h4000_0000, "post_reset_result");
        check("post_reset_start_count", 32'(start_cnt - s0), 32'd1);
        check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
